// File: rtl/constants_pkg.sv
// Shared constants for the ALU pipeline and its result buffer.
package constants_pkg;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'd0,
    ALU_SUB   = 2'd1,
    ALU_AND   = 2'd2,
    ALU_PASSB = 2'd3
  } alu_op_e;

  localparam int PIPE_LATENCY = 3;
  localparam int RBUF_DEPTH   = 4;

endpackage

// File: rtl/valid_delay.sv
// Tracks issued operations through the pipeline: one valid bit per stage,
// plus a count of how many stages currently carry a real operation.
module valid_delay
  import constants_pkg::*;
#(
  parameter  int LATENCY = PIPE_LATENCY,
  localparam int IW      = $clog2(LATENCY + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_i,
  output logic          valid_o,
  output logic [IW-1:0] inflight_o
);

  logic [LATENCY-1:0] r_sr;
  logic [IW-1:0]      w_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sr <= '0;
    end else begin
      r_sr[0] <= valid_i;
      for (int i = 1; i < LATENCY; i++) r_sr[i] <= r_sr[i-1];
    end
  end

  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < LATENCY; i++) w_cnt = w_cnt + IW'(r_sr[i]);
  end

  assign valid_o    = r_sr[LATENCY-1];
  assign inflight_o = w_cnt;

endmodule

// File: rtl/pipe_result_buffer.sv
// Captures pipeline results LATENCY edges after issue into a first-word
// fall-through FIFO and gates issue so that results in flight always fit.
module pipe_result_buffer
  import constants_pkg::*;
#(
  parameter  int DWIDTH  = 8,
  parameter  int DEPTH   = RBUF_DEPTH,
  parameter  int LATENCY = PIPE_LATENCY,
  localparam int CW      = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid_i,
  output logic              issue_ready_o,
  input  logic [DWIDTH-1:0] pipe_res_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DWIDTH-1:0] out_data_o,
  output logic [CW-1:0]     count_o,
  output logic              overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(LATENCY + 1);
  localparam int SW = CW + IW;

  logic              w_res_valid;
  logic [IW-1:0]     w_inflight;
  logic [SW-1:0]     w_occupancy;
  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;

  logic [DWIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_rptr;
  logic [AW-1:0]     r_wptr;
  logic [CW-1:0]     r_count;
  logic              r_overflow;

  valid_delay #(.LATENCY(LATENCY)) u_valid_delay (
    .clk        (clk),
    .rst        (rst),
    .valid_i    (issue_valid_i),
    .valid_o    (w_res_valid),
    .inflight_o (w_inflight)
  );

  // Output handshake: a result transfers on a rising edge where out_valid_o
  // and out_ready_i are both high; out_data_o holds steady until then.
  // issue_ready_o is advisory: issues made while it is low are still tracked.
  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == CW'(DEPTH));
  assign w_pop       = out_ready_i && !w_empty;
  assign w_push      = w_res_valid && (!w_full || w_pop);
  assign w_drop      = w_res_valid && w_full && !w_pop;
  assign w_occupancy = SW'(r_count) + SW'(w_inflight);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_rptr     <= '0;
      r_wptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= pipe_res_i;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      r_overflow <= r_overflow | w_drop;
    end
  end

  assign issue_ready_o = (w_occupancy < SW'(DEPTH));
  assign out_valid_o   = !w_empty;
  assign out_data_o    = r_mem[r_rptr];
  assign count_o       = r_count;
  assign overflow_o    = r_overflow;

endmodule

// File: tb/tb_pipe_result_buffer.sv
// Directed bench for pipe_result_buffer with a pass-op2 pipeline model
// and an expected-result queue.
module tb_pipe_result_buffer;
  import constants_pkg::*;

  localparam int DW = 8;
  localparam int CW = $clog2(RBUF_DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          issue_valid_i = 1'b0;
  logic          issue_ready_o;
  logic [DW-1:0] pipe_res_i;
  logic          out_valid_o;
  logic          out_ready_i = 1'b0;
  logic [DW-1:0] out_data_o;
  logic [CW-1:0] count_o;
  logic          overflow_o;

  logic [DW-1:0] op1 = '0;
  logic [DW-1:0] op2 = '0;
  logic [DW-1:0] pipe_q [PIPE_LATENCY];

  logic [DW-1:0] exp_q [$];
  int            n_checks = 0;
  int            n_errors = 0;
  int            n_issued;

  pipe_result_buffer dut (
    .clk           (clk),
    .rst           (rst),
    .issue_valid_i (issue_valid_i),
    .issue_ready_o (issue_ready_o),
    .pipe_res_i    (pipe_res_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .out_data_o    (out_data_o),
    .count_o       (count_o),
    .overflow_o    (overflow_o)
  );

  // clock / reset-independent pipeline model: result = op2 after PIPE_LATENCY edges
  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    pipe_q[0] <= op2;
    for (int i = 1; i < PIPE_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
  end
  assign pipe_res_i = pipe_q[PIPE_LATENCY-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of pipeline input; real issues are recorded if they will be kept.
  task automatic issue(input logic v, input logic [DW-1:0] b, input logic keep);
    issue_valid_i = v;
    op1 = DW'($urandom_range(0, 255));
    op2 = v ? b : DW'($urandom_range(0, 255));
    if (v && keep) exp_q.push_back(b);
    step();
    issue_valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) issue(1'b0, '0, 1'b0);
  endtask

  task automatic drain(input int n, input string tag);
    out_ready_i = 1'b1;
    for (int i = 0; i < n; i++) begin
      chk({tag, "_valid"}, 32'(out_valid_o), 32'd1);
      if (exp_q.size() == 0) begin
        chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd1);
      end else begin
        chk({tag, "_data"}, 32'(out_data_o), 32'(exp_q[0]));
        void'(exp_q.pop_front());
      end
      step();
      chk({tag, "_count"}, 32'(count_o), 32'(exp_q.size()));
    end
    out_ready_i = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"},    32'(out_valid_o),   32'd0);
    chk({tag, "_data"},     32'(out_data_o),    32'd0);
    chk({tag, "_count"},    32'(count_o),       32'd0);
    chk({tag, "_overflow"}, 32'(overflow_o),    32'd0);
    chk({tag, "_ready"},    32'(issue_ready_o), 32'd1);
  endtask

  initial begin
    // reset state
    #12;
    chk_reset_outputs("reset");
    @(posedge clk);
    #3 rst = 1'b1;
    step();

    // three issues back to back, result latency and head value
    issue(1'b1, 8'd25, 1'b1);
    issue(1'b1, 8'd30, 1'b1);
    issue(1'b1, 8'd10, 1'b1);
    chk("lat_before", 32'(out_valid_o), 32'd0);
    idle(1);
    chk("lat_valid", 32'(out_valid_o), 32'd1);
    chk("lat_count1", 32'(count_o), 32'd1);
    chk("lat_head1", 32'(out_data_o), 32'd25);
    idle(1);
    chk("lat_count2", 32'(count_o), 32'd2);
    idle(1);
    chk("lat_count3", 32'(count_o), 32'd3);
    chk("lat_head3", 32'(out_data_o), 32'd25);

    // pop in order until empty, then pop on empty is ignored
    drain(3, "pop");
    chk("pop_valid_fall", 32'(out_valid_o), 32'd0);
    out_ready_i = 1'b1;
    idle(2);
    out_ready_i = 1'b0;
    chk("empty_pop_count", 32'(count_o), 32'd0);

    // bubbles between issues write nothing
    issue(1'b1, 8'd7, 1'b1);
    idle(2);
    issue(1'b1, 8'd9, 1'b1);
    idle(PIPE_LATENCY + 1);
    chk("bubble_count", 32'(count_o), 32'd2);
    drain(2, "bubble");

    // issue while ready: exactly DEPTH issues accepted
    n_issued = 0;
    for (int i = 0; i < 10; i++) begin
      if (!issue_ready_o) break;
      issue(1'b1, DW'(8'h40 + i), 1'b1);
      n_issued++;
    end
    chk("fill_issues", 32'(n_issued), 32'(RBUF_DEPTH));
    chk("fill_ready_low", 32'(issue_ready_o), 32'd0);
    idle(PIPE_LATENCY + 1);
    chk("fill_count", 32'(count_o), 32'(RBUF_DEPTH));
    chk("fill_overflow", 32'(overflow_o), 32'd0);

    // forced issue into a full buffer is dropped and flagged
    issue(1'b1, 8'hEE, 1'b0);
    idle(PIPE_LATENCY);
    chk("drop_overflow", 32'(overflow_o), 32'd1);
    chk("drop_count", 32'(count_o), 32'(RBUF_DEPTH));
    chk("drop_head", 32'(out_data_o), 32'h40);

    // write and pop on the same edge while full
    issue(1'b1, 8'h55, 1'b1);
    idle(PIPE_LATENCY - 1);
    out_ready_i = 1'b1;
    chk("full_rw_head", 32'(out_data_o), 32'(exp_q[0]));
    void'(exp_q.pop_front());
    step();
    out_ready_i = 1'b0;
    chk("full_rw_count", 32'(count_o), 32'(RBUF_DEPTH));
    chk("full_rw_overflow", 32'(overflow_o), 32'd1);
    drain(RBUF_DEPTH, "after_drop");
    chk("sticky_overflow", 32'(overflow_o), 32'd1);

    // asynchronous reset with two stored and two in flight
    issue(1'b1, 8'h11, 1'b1);
    issue(1'b1, 8'h22, 1'b1);
    idle(PIPE_LATENCY);
    issue(1'b1, 8'h33, 1'b1);
    issue(1'b1, 8'h44, 1'b1);
    chk("pre_reset_count", 32'(count_o), 32'd2);
    #2 rst = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    exp_q.delete();
    step();
    step();
    #3 rst = 1'b1;
    idle(PIPE_LATENCY + 2);
    chk("post_reset_count", 32'(count_o), 32'd0);
    chk("post_reset_valid", 32'(out_valid_o), 32'd0);

    // buffer works normally after reset
    issue(1'b1, 8'h42, 1'b1);
    idle(PIPE_LATENCY);
    chk("post_reset_write", 32'(count_o), 32'd1);
    drain(1, "post_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_result_buffer.md
PIPE_RESULT_BUFFER -- requirements
Module: pipe_result_buffer

Interface
REQ-001 Parameter DWIDTH, default 8, SHALL set operand/result data width (matches three_stage_pipeline).
REQ-002 Parameter DEPTH, default 4, SHALL set result FIFO entries; power of two, >= 2.
REQ-003 Parameter LATENCY, default PIPE_LATENCY (3), SHALL set pipeline result latency in clock edges.
REQ-004 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 rst  input  1  SHALL be the reset: asynchronous, active-low (0 = reset asserted).
REQ-006 issue_valid_i  input  1  SHALL flag that op1/op2 presented to the pipeline this cycle are a real operation.
REQ-007 issue_ready_o  output  1  SHALL indicate the upstream may issue this cycle without risking overflow.
REQ-008 pipe_res_i  input  DWIDTH  SHALL carry three_stage_pipeline res_o.
REQ-009 out_valid_o  output  1  SHALL be high when the FIFO holds at least one result.
REQ-010 out_ready_i  input  1  SHALL accept the head result when high with out_valid_o.
REQ-011 out_data_o  output  DWIDTH  SHALL show the head result (first-word fall-through).
REQ-012 count_o  output  $clog2(DEPTH)+1  SHALL report stored entries, 0..DEPTH.
REQ-013 overflow_o  output  1  SHALL be a sticky flag set when a result is dropped for lack of space.

Function
REQ-014 An issue SHALL occur on an edge where issue_valid_i=1; issues with issue_ready_o=0 are still tracked.
REQ-015 Issue tracking SHALL use a LATENCY-bit valid shift register: bit0 loads issue_valid_i each edge, bit[LATENCY-1] marks pipe_res_i as valid.
REQ-016 An issue sampled at edge E SHALL cause pipe_res_i to be written into the FIFO at edge E+LATENCY; out_valid_o visible after that edge.
REQ-017 Cycles with issue_valid_i=0 SHALL produce no FIFO write LATENCY edges later (bubbles discarded).
REQ-018 issue_ready_o SHALL equal (count_o + in-flight count) < DEPTH, in-flight count = popcount of the shift register; combinational.
REQ-019 Pop SHALL occur when out_valid_o and out_ready_i are high; read pointer advances, count_o decrements.
REQ-020 Pop with FIFO empty SHALL be ignored: no pointer change, count_o stays 0.
REQ-021 Simultaneous write and pop SHALL both take effect, count_o unchanged, including when count_o=DEPTH.
REQ-022 Write with count_o=DEPTH and no pop SHALL drop the result, leave contents intact, set overflow_o.
REQ-023 Read/write pointers SHALL wrap modulo DEPTH; full/empty SHALL derive from count_o, not pointer equality.
REQ-024 out_data_o SHALL equal storage at read pointer; order SHALL be strict issue order.
REQ-025 overflow_o SHALL remain set until reset.

Reset
REQ-026 rst=0 SHALL immediately clear shift register, pointers, count_o, overflow_o and all storage to 0, independent of clk.
REQ-027 During reset out_valid_o=0, out_data_o=0, count_o=0, overflow_o=0, issue_ready_o=1.
REQ-028 Reset mid-operation SHALL discard in-flight and stored results; first edge after rst=1 behaves as from empty.

Structure
REQ-029 PIPE_LATENCY (3) and RBUF_DEPTH (4) SHALL live in constants_pkg beside the ALU op encodings.
REQ-030 The valid shift register with popcount SHALL be a sub-module named valid_delay (params LATENCY; ports clk, rst, valid_i, valid_o, inflight_o).
REQ-031 FIFO storage and pointers SHALL be in pipe_result_buffer itself; no vendor macros.

Verification
REQ-032 Issue 100/25, 50/30, 75/10 on consecutive edges, out_ready_i=0 -> out_valid_o rises 3 edges after first issue; count_o 1,2,3; out_data_o=25.
REQ-033 Then out_ready_i=1 for 3 cycles -> pops 25, 30, 10 in order; count_o reaches 0; out_valid_o falls.
REQ-034 Issue, 2 bubbles, issue (op2=7, 9) -> only 2 entries written (7 then 9); bubble results ignored.
REQ-035 out_ready_i=0, issue every cycle while issue_ready_o=1 -> issue_ready_o falls after 4 issues; count_o settles at 4; overflow_o stays 0.
REQ-036 Force 5th issue ignoring issue_ready_o -> 5th result dropped, overflow_o=1 sticky, entries 1-4 intact; simultaneous pop at full keeps count_o=4.
REQ-037 Drop rst to 0 with 2 stored, 2 in flight -> all outputs to reset values immediately; no writes after release.
